// File: rtl/gate_pipe_pkg.sv
// gate_pipe_pkg
//   Shared definitions for the gate pipe unit and its reduction datapath:
//   op-code encoding, op-code width and the upper bound on operand count.
package gate_pipe_pkg;

   localparam int OP_W       = 3;
   localparam int MAX_NUM_IN = 8;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_PASS = 3'd6,
      OP_NOT  = 3'd7
   } op_e;

endpackage

// File: rtl/gate_pipe_unit_reduce.sv
// gate_reduce
//   Combinational bitwise reduction of NUM_IN operands under a 3-bit op code.
//   Ports:
//     operands  in   NUM_IN*WIDTH  operand k at [k*WIDTH +: WIDTH]
//     op        in   3             op code (gate_pipe_pkg::op_e)
//     result    out  WIDTH         reduced result
module gate_reduce
   import gate_pipe_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 2
) (
   input  logic [NUM_IN*WIDTH-1:0] operands,
   input  logic [OP_W-1:0]         op,
   output logic [WIDTH-1:0]        result
);

   logic [WIDTH-1:0] and_r, or_r, xor_r;

   always_comb begin
      and_r = '1;
      or_r  = '0;
      xor_r = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         and_r = and_r & operands[k*WIDTH +: WIDTH];
         or_r  = or_r  | operands[k*WIDTH +: WIDTH];
         xor_r = xor_r ^ operands[k*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      result = '0;
      case (op_e'(op))
         OP_AND:  result = and_r;
         OP_OR:   result = or_r;
         OP_XOR:  result = xor_r;
         OP_NAND: result = ~and_r;
         OP_NOR:  result = ~or_r;
         OP_XNOR: result = ~xor_r;
         OP_PASS: result = operands[WIDTH-1:0];
         OP_NOT:  result = ~operands[WIDTH-1:0];
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/gate_pipe_unit.sv
// gate_pipe_unit
//   Two-stage valid/ready pipeline applying a selectable bitwise op across
//   NUM_IN operands of WIDTH bits (NUM_IN legal range 2..MAX_NUM_IN).
//   Stage 1 registers the operands and op; stage 2 registers the reduced result.
//   Ports:
//     clk, rst           clock, asynchronous active-high reset
//     in_data/in_op      packed operands and op code, sampled on input transfer
//     in_valid/in_ready  input handshake (in_ready has no path from in_valid)
//     out_data           result
//     out_valid/out_ready output handshake
//   Optional (macro GATE_PIPE_STATS_EN):
//     stat_xfer_cnt      output transfers, wraps mod 2^32
//     stat_ones_cnt      output transfers whose result is all ones
module gate_pipe_unit
   import gate_pipe_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [OP_W-1:0]         in_op,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready
`ifdef GATE_PIPE_STATS_EN
   ,
   output logic [31:0]             stat_xfer_cnt,
   output logic [31:0]             stat_ones_cnt
`endif
);

   logic                    s1_valid;
   logic [NUM_IN*WIDTH-1:0] s1_data;
   logic [OP_W-1:0]         s1_op;
   logic [WIDTH-1:0]        s1_result;
   logic                    s2_free;
   logic                    in_xfer;

   assign s2_free  = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_free;
   assign in_xfer  = in_valid && in_ready;

   // Stage 1 only loads on a real transfer, so idle X on in_data never enters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_op    <= '0;
      end else if (in_xfer) begin
         s1_valid <= 1'b1;
         s1_data  <= in_data;
         s1_op    <= in_op;
      end else if (s2_free) begin
         s1_valid <= 1'b0;
      end
   end

   gate_reduce #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_reduce (
      .operands (s1_data),
      .op       (s1_op),
      .result   (s1_result)
   );

   // out_data keeps its last value when a bubble moves in, holding it stable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (s2_free) begin
         out_valid <= s1_valid;
         if (s1_valid) out_data <= s1_result;
      end
   end

`ifdef GATE_PIPE_STATS_EN
   logic out_xfer;
   assign out_xfer = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_xfer_cnt <= '0;
         stat_ones_cnt <= '0;
      end else if (out_xfer) begin
         stat_xfer_cnt <= stat_xfer_cnt + 32'd1;
         if (&out_data) stat_ones_cnt <= stat_ones_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_gate_pipe_unit.sv
module tb_gate_pipe_unit;
   localparam int WIDTH  = 8;
   localparam int NUM_IN = 4;
   localparam int DW     = WIDTH*NUM_IN;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [DW-1:0]    in_data = '0;
   logic [2:0]       in_op = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready = 1'b1;
`ifdef GATE_PIPE_STATS_EN
   logic [31:0]      stat_xfer_cnt, stat_ones_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;
   bit rand_bp = 1'b0;
   logic [WIDTH-1:0] sb[$];

   gate_pipe_unit #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_op(in_op),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready)
`ifdef GATE_PIPE_STATS_EN
      , .stat_xfer_cnt(stat_xfer_cnt), .stat_ones_cnt(stat_ones_cnt)
`endif
   );

   // 1-bit, 2-input reduction for the truth-table check
   logic [1:0] tt_ab;
   logic [2:0] tt_op;
   logic       tt_res;
   gate_reduce #(.WIDTH(1), .NUM_IN(2)) u_tt (.operands(tt_ab), .op(tt_op), .result(tt_res));

   always #5 clk = ~clk;

   // Reference: per bit, count ones across operands and apply the op rule.
   function automatic logic [WIDTH-1:0] model(input logic [DW-1:0] d, input logic [2:0] op);
      logic [WIDTH-1:0] r;
      for (int b = 0; b < WIDTH; b++) begin
         int ones = 0;
         for (int k = 0; k < NUM_IN; k++) ones += int'(d[k*WIDTH+b]);
         case (op)
            3'd0: r[b] = (ones == NUM_IN);
            3'd1: r[b] = (ones > 0);
            3'd2: r[b] = (ones % 2 == 1);
            3'd3: r[b] = !(ones == NUM_IN);
            3'd4: r[b] = !(ones > 0);
            3'd5: r[b] = !(ones % 2 == 1);
            3'd6: r[b] = d[b];
            default: r[b] = !d[b];
         endcase
      end
      return r;
   endfunction

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   // Monitor / scoreboard, sampling mid-cycle where all signals are settled.
   logic             prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_data = '0;
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && out_valid) check("stall_hold", {24'd0, out_data}, {24'd0, prev_data});
         if (prev_stall) check("stall_valid", {31'd0, out_valid}, 32'd1);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_output actual=%0h required=none", out_data);
            end else begin
               check("sb_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         if (in_valid && in_ready) begin
            sb.push_back(model(in_data, in_op));
            acc_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #2;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
   endtask

   // Present one transaction; returns at the mid-cycle point where it is accepted.
   task automatic send(input logic [DW-1:0] d, input logic [2:0] op, input bit jitter_op);
      int n = 0;
      tick();
      in_valid = 1'b1; in_data = d; in_op = op;
      @(negedge clk);
      while (!in_ready && n < 500) begin
         tick();
         if (jitter_op) in_op = 3'($urandom_range(0, 7));
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout actual=stalled required=accept");
      end
   endtask

   task automatic idle();
      tick();
      in_valid = 1'b0; in_data = 'x; in_op = 'x;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < 500) begin
         @(negedge clk); n++;
      end
      check("drain", {31'd0, (sb.size() == 0 && !out_valid)}, 32'd1);
   endtask

   task automatic run_one(input logic [DW-1:0] d, input logic [2:0] op,
                          input logic [WIDTH-1:0] exp, input string name);
      int n = 0;
      send(d, op, 1'b0);
      idle();
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      check(name, {24'd0, out_data}, {24'd0, exp});
      drain();
   endtask

   logic [3:0] tt_exp[6];
   bit         done5;
   int         gaps;
   logic [DW-1:0] wide;

   initial begin
      tt_exp[0] = 4'b1000; tt_exp[1] = 4'b1110; tt_exp[2] = 4'b0110;
      tt_exp[3] = 4'b0111; tt_exp[4] = 4'b0001; tt_exp[5] = 4'b1001;

      // Reset state
      #13;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      @(posedge clk); #2 rst = 1'b0;

      // Truth table on a 1-bit, 2-input reducer
      for (int op = 0; op < 6; op++)
         for (int ab = 0; ab < 4; ab++) begin
            logic [3:0] row;
            tt_op = 3'(op); tt_ab = 2'(ab); row = tt_exp[op];
            #1 check($sformatf("tt_op%0d_ab%0d", op, ab), {31'd0, tt_res}, {31'd0, row[ab]});
         end

      // Latency: accepted at this mid-cycle, visible two mid-cycles later
      begin
         int n = 0;
         send(32'h0102_0304, 3'd1, 1'b0);
         idle();
         n = 1;
         @(negedge clk);
         while (!out_valid && n < 10) begin @(negedge clk); n++; end
         check("latency", n, 2);
         drain();
      end

      // Wide multi-operand
      wide = {8'hFF, 8'hAA, 8'hCC, 8'hF0};
      run_one(wide, 3'd0, 8'h80, "wide_and");
      run_one(wide, 3'd1, 8'hFF, "wide_or");
      run_one(wide, 3'd2, 8'h69, "wide_xor");
      run_one(wide, 3'd4, 8'h00, "wide_nor");

      // Backpressure: 5 ORs with the sink stalled
      out_ready = 1'b0;
      acc_cnt = 0;
      done5 = 1'b0;
      fork
         begin
            for (int i = 0; i < 5; i++) send(DW'($urandom), 3'd1, 1'b1);
            idle();
            done5 = 1'b1;
         end
      join_none
      repeat (8) @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_accepted", acc_cnt, 2);
      @(posedge clk); #2 out_ready = 1'b1;
      begin
         int n = 0;
         while (!done5 && n < 100) begin @(negedge clk); n++; end
         check("bp_done", {31'd0, done5}, 32'd1);
      end
      drain();
      check("bp_total", acc_cnt, 5);

      // Full-rate simultaneous transfer
      gaps = 0;
      fork
         begin
            for (int i = 0; i < 16; i++) send(DW'($urandom), 3'($urandom_range(0, 7)), 1'b0);
            idle();
         end
         begin
            int n = 0;
            while (!out_valid && n < 20) begin @(negedge clk); n++; end
            for (int i = 0; i < 16; i++) begin
               if (!out_valid) gaps++;
               if (i < 15) @(negedge clk);
            end
         end
      join
      check("fullrate_gaps", gaps, 0);
      drain();

      // Async reset with two transactions in flight
      send(DW'($urandom), 3'd2, 1'b0);
      send(DW'($urandom), 3'd3, 1'b0);
      idle();
      #1 rst = 1'b1;
      #1;
      check("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check("arst_out_data", {24'd0, out_data}, 32'd0);
      check("arst_in_ready", {31'd0, in_ready}, 32'd1);
      sb.delete();
      @(posedge clk); #2 rst = 1'b0;
      check("arst_rel_in_ready", {31'd0, in_ready}, 32'd1);
      gaps = 0;
      repeat (6) begin @(negedge clk); if (out_valid) gaps++; end
      check("arst_no_stale", gaps, 0);

      // Randomized traffic with random backpressure and idle gaps
      rand_bp = 1'b1;
      for (int i = 0; i < 200; i++) begin
         send(DW'($urandom), 3'($urandom_range(0, 7)), 1'b1);
         if ($urandom_range(0, 3) == 0) begin
            idle();
            repeat ($urandom_range(0, 2)) tick();
         end
      end
      idle();
      rand_bp = 1'b0;
      out_ready = 1'b1;
      drain();

`ifdef GATE_PIPE_STATS_EN
      @(posedge clk); #1 rst = 1'b1;
      #2 rst = 1'b0;
      sb.delete();
      for (int i = 0; i < 10; i++) begin
         if (i % 3 == 0 && i < 9) send({4{8'hFF}}, 3'd0, 1'b0);
         else send(DW'({$urandom_range(0, 127)}), 3'd6, 1'b0);
      end
      idle();
      drain();
      check("stat_xfer", stat_xfer_cnt, 32'd10);
      check("stat_ones", stat_ones_cnt, 32'd3);
      @(posedge clk); #1 rst = 1'b1;
      #2;
      check("stat_xfer_rst", stat_xfer_cnt, 32'd0);
      check("stat_ones_rst", stat_ones_cnt, 32'd0);
      rst = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
